// File: rtl/mash_accumulators.sv
// -----------------------------------------------------------------------------
// mash_accumulators
//
// Three cascaded first-order accumulators (MASH 1-1-1) for a fractional-N
// delta-sigma modulator. The fractional word is held in a local register
// that is loaded through a single-cycle strobe. The per-cycle carries c1/c2/c3
// all belong to the same sample, which is the alignment the noise shaper
// downstream expects.
//
// Ports:
//   clk        modulator clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   en         accumulate enable (low = hold accumulators, carries forced 0)
//   clr        synchronous clear of accumulators, carries (and dither LFSR)
//   frac_in    unsigned fractional word, value / 2^WIDTH
//   frac_load  single-cycle strobe capturing frac_in
//   frac_q     currently applied fractional word
//   c1, c2, c3 registered carries of stages 1..3
//   load_ack   one-cycle pulse in the cycle after a capture
//
// Optional feature macro: MASH_DITHER_EN
//   When defined, a 15-bit Fibonacci LFSR (x^15 + x^14 + 1, seed 15'h0001)
//   supplies an LSB carry-in to stage 1 to break idle tones. When undefined,
//   no LFSR exists and s1 = acc1 + frac_q exactly.
// -----------------------------------------------------------------------------
module mash_accumulators #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] frac_in,
    input  logic             frac_load,
    output logic [WIDTH-1:0] frac_q,
    output logic             c1,
    output logic             c2,
    output logic             c3,
    output logic             load_ack
);

    logic [WIDTH-1:0] r_frac;
    logic [WIDTH-1:0] r_acc1;
    logic [WIDTH-1:0] r_acc2;
    logic [WIDTH-1:0] r_acc3;
    logic             r_c1;
    logic             r_c2;
    logic             r_c3;
    logic             r_ack;

    logic [WIDTH:0]   w_s1;
    logic [WIDTH:0]   w_s2;
    logic [WIDTH:0]   w_s3;
    logic             w_dither;

`ifdef MASH_DITHER_EN
    logic [14:0]      r_lfsr;

    assign w_dither = r_lfsr[0];

    // Dither LFSR: reseeded on clear, advances once per enabled edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 15'h0001;
        end else if (clr) begin
            r_lfsr <= 15'h0001;
        end else if (en) begin
            r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
        end else begin
            r_lfsr <= r_lfsr;
        end
    end
`else
    assign w_dither = 1'b0;
`endif

    // Unpipelined accumulator chain; each stage integrates the previous sum
    always_comb begin
        w_s1 = {1'b0, r_acc1} + {1'b0, r_frac} + {{WIDTH{1'b0}}, w_dither};
        w_s2 = {1'b0, r_acc2} + {1'b0, w_s1[WIDTH-1:0]};
        w_s3 = {1'b0, r_acc3} + {1'b0, w_s2[WIDTH-1:0]};
    end

    // Accumulator and carry registers: clear beats enable, disabled edges zero the carries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc1 <= {WIDTH{1'b0}};
            r_acc2 <= {WIDTH{1'b0}};
            r_acc3 <= {WIDTH{1'b0}};
            r_c1   <= 1'b0;
            r_c2   <= 1'b0;
            r_c3   <= 1'b0;
        end else if (clr) begin
            r_acc1 <= {WIDTH{1'b0}};
            r_acc2 <= {WIDTH{1'b0}};
            r_acc3 <= {WIDTH{1'b0}};
            r_c1   <= 1'b0;
            r_c2   <= 1'b0;
            r_c3   <= 1'b0;
        end else if (en) begin
            r_acc1 <= w_s1[WIDTH-1:0];
            r_acc2 <= w_s2[WIDTH-1:0];
            r_acc3 <= w_s3[WIDTH-1:0];
            r_c1   <= w_s1[WIDTH];
            r_c2   <= w_s2[WIDTH];
            r_c3   <= w_s3[WIDTH];
        end else begin
            r_acc1 <= r_acc1;
            r_acc2 <= r_acc2;
            r_acc3 <= r_acc3;
            r_c1   <= 1'b0;
            r_c2   <= 1'b0;
            r_c3   <= 1'b0;
        end
    end

    // Fractional word register and its acknowledge; independent of en and clr,
    // so an accumulation on the load edge still uses the old word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frac <= {WIDTH{1'b0}};
            r_ack  <= 1'b0;
        end else if (frac_load) begin
            r_frac <= frac_in;
            r_ack  <= 1'b1;
        end else begin
            r_frac <= r_frac;
            r_ack  <= 1'b0;
        end
    end

    assign frac_q   = r_frac;
    assign c1       = r_c1;
    assign c2       = r_c2;
    assign c3       = r_c3;
    assign load_ack = r_ack;

endmodule

// File: tb/tb_mash_accumulators.sv
// -----------------------------------------------------------------------------
// tb_mash_accumulators
//
// Self-checking bench for mash_accumulators at WIDTH=4. A reference model
// written with plain modular arithmetic tracks the three accumulators, the
// carries, the fractional word and the load acknowledge; every output is
// compared after each clock edge. Directed sections cover reset, half-rate,
// hold, clear, load collision and the mean property; a randomized section
// and a mid-run asynchronous reset follow.
// -----------------------------------------------------------------------------
module tb_mash_accumulators;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         clr;
    logic [W-1:0] frac_in;
    logic         frac_load;
    logic [W-1:0] frac_q;
    logic         c1;
    logic         c2;
    logic         c3;
    logic         load_ack;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_acc [3];
    int m_c   [3];
    int m_frac;
    int m_ack;
    int m_lfsr;

    always #5 clk = ~clk;

    mash_accumulators #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .frac_in   (frac_in),
        .frac_load (frac_load),
        .frac_q    (frac_q),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .load_ack  (load_ack)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0;
            m_c[k]   = 0;
        end
        m_frac = 0;
        m_ack  = 0;
        m_lfsr = 1;
    endtask

    // one clock edge of the reference behaviour, using inputs present at the edge
    task automatic model_edge();
        int x;
        int s;
        if (clr) begin
            for (int k = 0; k < 3; k++) begin
                m_acc[k] = 0;
                m_c[k]   = 0;
            end
            m_lfsr = 1;
        end else if (en) begin
            x = m_frac;
`ifdef MASH_DITHER_EN
            x = x + (m_lfsr & 1);
            m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) & 32'h7fff;
`endif
            for (int k = 0; k < 3; k++) begin
                s        = m_acc[k] + x;
                m_c[k]   = s / M;
                m_acc[k] = s % M;
                x        = m_acc[k];
            end
        end else begin
            for (int k = 0; k < 3; k++) m_c[k] = 0;
        end
        if (frac_load) m_frac = int'(frac_in);
        m_ack = int'(frac_load);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".frac_q"},   int'(frac_q),   m_frac);
        chk({tag, ".c1"},       int'(c1),       m_c[0]);
        chk({tag, ".c2"},       int'(c2),       m_c[1]);
        chk({tag, ".c3"},       int'(c3),       m_c[2]);
        chk({tag, ".load_ack"}, int'(load_ack), m_ack);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic chk3(input string tag, input int e1, input int e2, input int e3);
        chk({tag, ".c1"}, int'(c1), e1);
        chk({tag, ".c2"}, int'(c2), e2);
        chk({tag, ".c3"}, int'(c3), e3);
    endtask

    task automatic load_word(input int w);
        frac_in   = W'(w);
        frac_load = 1'b1;
        tick("load");
        frac_load = 1'b0;
    endtask

    initial begin
        int ones;
        rst_n     = 1'b0;
        en        = 1'b0;
        clr       = 1'b0;
        frac_in   = '0;
        frac_load = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // half rate: frac = 8
        load_word(8);
        chk("half.ack", int'(load_ack), 1);
        en = 1'b1;
        tick("half1");
`ifndef MASH_DITHER_EN
        chk3("half1k", 0, 0, 0);
`endif
        tick("half2");
`ifndef MASH_DITHER_EN
        chk3("half2k", 1, 0, 1);
`endif
        tick("half3");
`ifndef MASH_DITHER_EN
        chk3("half3k", 0, 1, 0);
`endif
        for (int i = 0; i < 5; i++) tick("half");

        // hold for 10 cycles then resume
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick("hold");
            chk3("holdk", 0, 0, 0);
        end
        en = 1'b1;
        for (int i = 0; i < 6; i++) tick("resume");

        // clear: sequence restarts as from reset, frac retained
        clr = 1'b1;
        tick("clr");
        chk("clr.frac", int'(frac_q), 8);
        clr = 1'b0;
        tick("clr1");
`ifndef MASH_DITHER_EN
        chk3("clr1k", 0, 0, 0);
`endif
        tick("clr2");
`ifndef MASH_DITHER_EN
        chk3("clr2k", 1, 0, 1);
`endif

        // load collision: load 3 during enabled edge with frac_q=8
        frac_in   = W'(3);
        frac_load = 1'b1;
        tick("coll");
        frac_load = 1'b0;
        chk("coll.frac", int'(frac_q), 3);
        tick("coll_next");
        chk("coll.ack_once", int'(load_ack), 0);

        // mean: 16 enabled edges with frac 5
        en = 1'b0;
        load_word(5);
        en   = 1'b1;
        ones = 0;
        for (int i = 0; i < M; i++) begin
            tick("mean");
            ones += int'(c1);
        end
`ifndef MASH_DITHER_EN
        chk("mean.ones", ones, 5);
`endif

`ifdef MASH_DITHER_EN
        // dither: frac 0 still produces carries
        load_word(0);
        clr = 1'b1;
        tick("dclr");
        clr  = 1'b0;
        ones = 0;
        for (int i = 0; i < 4 * M; i++) begin
            tick("dither");
            ones += int'(c1);
        end
        chk("dither.nonzero", int'(ones > 0), 1);
`else
        // frac 0 from clear state: carries stay 0
        load_word(0);
        clr = 1'b1;
        tick("zclr");
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick("zero");
            chk3("zerok", 0, 0, 0);
        end
`endif

        // randomized operation
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(9) != 0);
            clr       = ($urandom_range(29) == 0);
            frac_load = ($urandom_range(11) == 0);
            frac_in   = W'($urandom_range(M - 1));
            tick("rand");
        end
        en        = 1'b1;
        clr       = 1'b0;
        frac_load = 1'b0;

        // asynchronous reset mid-run with nonzero word
        load_word(12);
        for (int i = 0; i < 5; i++) tick("pre_rst");
        @(posedge clk);
        model_edge();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        load_word(7);
        for (int i = 0; i < 20; i++) tick("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mash_accumulators.md
# mash_accumulators

Three-stage cascaded first-order accumulator core (MASH 1-1-1) for the fractional-N delta-sigma modulator. It takes a fractional frequency word and produces the per-cycle carry bits c1, c2 and c3. These feed directly into the noise shaper, which combines them into the signed fractional divider offset. The block holds the fractional word register, its load handshake and the synchronous clear, so the modulator can be retuned or restarted without a reset.

## Interface
- WIDTH, 16, accumulator and fractional word width in bits (≥ 2)
- clk  input  1  modulator clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  accumulate enable; low = hold state
- clr  input  1  synchronous clear of all three accumulators and carries
- frac_in  input  WIDTH  unsigned fractional word (value / 2^WIDTH)
- frac_load  input  1  single-cycle strobe; captures frac_in
- frac_q  output  WIDTH  currently applied fractional word
- c1  output  1  registered carry, stage 1
- c2  output  1  registered carry, stage 2
- c3  output  1  registered carry, stage 3
- load_ack  output  1  one-cycle pulse, the cycle after a capture

## Operation
- State: frac_q, acc1, acc2 and acc3 (WIDTH bits each), plus c1, c2, c3 and load_ack. All are 0 on reset.
- Per enabled edge (en=1, clr=0), combinational chain, unsigned with WIDTH+1-bit sums:
  - s1 = acc1 + frac_q (+ dither, see Configuration)
  - s2 = acc2 + s1[WIDTH-1:0]
  - s3 = acc3 + s2[WIDTH-1:0]
  - accK <= sK[WIDTH-1:0]; cK <= sK[WIDTH]
- The chain is not pipelined. All three carries belong to the same sample, which is the alignment the noise shaper requires.
- en=0, clr=0:
  - accumulators hold
  - c1/c2/c3 <= 0, so the shaper sees zero input
- clr=1:
  - acc1..3 <= 0 and c1..3 <= 0, regardless of en
  - frac_q is unaffected
- Load:
  - frac_load=1 at edge k: frac_q <= frac_in at edge k
  - load_ack=1 during cycle k+1
  - frac_load is honoured regardless of en or clr
- Simultaneous load and accumulate at edge k: the accumulation uses the old frac_q. The new word takes effect from edge k+1.
- Simultaneous clr and load: both take effect at the same edge.
- frac_q=0 with clear state: all carries remain 0 indefinitely.
- Mean of c1 over any 2^WIDTH consecutive enabled cycles equals frac_q / 2^WIDTH exactly, with no dither.
- Wrap-around is modular by design. No saturation.

## Timing
- Latency: frac_q change to first affected c1 is 1 enabled edge. Inputs are registered at that edge.
- Outputs are registered, with no combinational path from any input to any output.
- Reset asserted mid-operation: all state goes to 0 immediately (asynchronous). Operation restarts cleanly on the first edge after deassertion.
- load_ack is never asserted for two consecutive cycles unless frac_load is held high. Each high cycle of frac_load is treated as a separate capture.

## Configuration
- MASH_DITHER_EN defined:
  - adds a 15-bit Fibonacci LFSR (x^15 + x^14 + 1, seed 15'h0001 on reset and on clr)
  - LFSR advances once per enabled edge
  - bit 0 is added to s1 as an LSB carry-in
  - breaks idle tones at rational fractional words
- MASH_DITHER_EN undefined:
  - no LFSR is instantiated
  - s1 = acc1 + frac_q exactly
  - the mean property above holds bit-exactly

## Test plan
- **Reset:** rst_n low mid-run with frac_q=16'h1234 → frac_q, c1..3 and load_ack all read 0 in the same cycle, before any clock edge.
- **Half rate:** WIDTH=4, frac_load frac_in=8, then en=1.
  - c1 sequence: 0,1,0,1,…
  - (c2,c3) over the first 3 edges: (0,0), (0,1), (1,0)
- **Mean:** WIDTH=4, frac_in=5, 16 enabled edges → exactly 5 ones on c1 (no dither).
- **Hold and clear:**
  - en=0 for 10 cycles → carries 0, accumulators unchanged; resuming continues the prior sequence
  - clr=1 → next edge gives acc1..3=0, and the sequence restarts as from reset with frac_q retained
- **Load collision:** frac_load with frac_in=3 while en=1 and frac_q=8 → that edge uses 8; the next edge uses 3; load_ack high for exactly 1 cycle.
- **Dither (MASH_DITHER_EN):** WIDTH=4, frac_in=0 → c1 toggles at a non-zero rate, and the LFSR sequence matches the reference model from seed 1.
